legv8_multicycle_control: RTL and testbench

LEGV8_MULTICYCLE_CONTROL -- requirements
Module: legv8_multicycle_control

---
 rtl/legv8_multicycle_control_pkg.sv | 85 ++++++++
 rtl/legv8_multicycle_control_if.sv | 31 +++
 rtl/legv8_decoder.sv | 165 ++++++++++++++++
 rtl/legv8_multicycle_control.sv | 68 ++++++
 tb/tb_legv8_multicycle_control.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/legv8_multicycle_control_pkg.sv
// LEGv8 multicycle control: shared definitions.
// Holds the FSM state encoding, opcode constants, ALU function (FS) codes,
// PC-select (PS) codes, branch condition codes, and the control-word layout.
// It also holds the immediate extension helpers used by the decoder.
// The package is imported by the interface, the decoder and the top.
package legv8_multicycle_control_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_MEM   = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  // 11-bit opcodes (IR[31:21])
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // 10-bit opcodes (IR[31:22])
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  // 8-bit opcodes (IR[31:24])
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  // 6-bit opcode (IR[31:26])
  localparam logic [5:0]  OP_B     = 6'b000101;

  // ALU function select
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  // PC select: hold, increment by 4, add branch offset
  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;

  // B.cond condition codes (IR[3:0])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;

  localparam int CW_W = 30;

  // Control word, MSB first
  typedef struct packed {
    logic       en_pc;
    logic       en_mem;
    logic       en_alu;
    logic       pc_sel;
    logic       b_sel;
    logic       sl;
    logic       wm;
    logic       wr;
    logic [1:0] ps;
    logic [4:0] fs;
    logic [4:0] sb;
    logic [4:0] sa;
    logic [4:0] da;
  } ctrl_t;

  function automatic logic [63:0] zext_imm12(input logic [11:0] imm);
    return {52'd0, imm};
  endfunction

  function automatic logic [63:0] sext_imm9(input logic [8:0] imm);
    return {{55{imm[8]}}, imm};
  endfunction

  // Branch offsets are word counts; scale to bytes
  function automatic logic [63:0] sext_imm19_x4(input logic [18:0] imm);
    return {{43{imm[18]}}, imm, 2'b00};
  endfunction

  function automatic logic [63:0] sext_imm26_x4(input logic [25:0] imm);
    return {{36{imm[25]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/legv8_multicycle_control_if.sv
// Bus between the LEGv8 control unit and its environment.
//   run          : 1 = sequence, 0 = freeze
//   instruction  : program ROM word, sampled into IR during FETCH
//   status       : {V,C,N,Z} in [4:1], live ALU zero in [0]
//   control_word : datapath control fields (see ctrl_t)
//   constant     : immediate / branch offset for the datapath
//   IL           : instruction-register load strobe
//   halted       : high while the FSM sits in HALT
// master = environment side, slave = control unit side.
interface legv8_multicycle_control_if;
  import legv8_multicycle_control_pkg::*;

  logic            run;
  logic [31:0]     instruction;
  logic [4:0]      status;
  logic [CW_W-1:0] control_word;
  logic [63:0]     constant;
  logic            IL;
  logic            halted;

  modport master (
    output run, instruction, status,
    input  control_word, constant, IL, halted
  );

  modport slave (
    input  run, instruction, status,
    output control_word, constant, IL, halted
  );

endinterface

// File: rtl/legv8_decoder.sv
// LEGv8 instruction decoder for the multicycle control unit.
// Purely combinational: maps (state, IR, status) to the control word,
// the datapath constant and the next FSM state.
//   state      : current FSM state
//   ir         : latched instruction register
//   status     : {V,C,N,Z} in [4:1], live ALU zero in [0]
//   ctrl       : decoded control word
//   constant   : immediate / offset, 0 when unused
//   next_state : FSM successor state
module legv8_decoder
  import legv8_multicycle_control_pkg::*;
(
  input  state_t      state,
  input  logic [31:0] ir,
  input  logic [4:0]  status,
  output ctrl_t       ctrl,
  output logic [63:0] constant,
  output state_t      next_state
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [3:0]  cond;
  logic        flag_v;
  logic        flag_n;
  logic        flag_z;
  logic        flag_c_unused;
  logic        alu_zero;
  logic        cond_taken;

  assign op11 = ir[31:21];
  assign op10 = ir[31:22];
  assign op8  = ir[31:24];
  assign op6  = ir[31:26];
  assign rd   = ir[4:0];   // also Rt for loads, stores and CBZ
  assign rn   = ir[9:5];
  assign rm   = ir[20:16];
  assign cond = ir[3:0];

  assign flag_v        = status[4];
  assign flag_c_unused = status[3];  // no supported condition reads carry
  assign flag_n        = status[2];
  assign flag_z        = status[1];
  assign alu_zero      = status[0];

  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_ORR) || (op == OP_SUBS);
  endfunction

  function automatic logic [4:0] rtype_fs(input logic [10:0] op);
    logic [4:0] fs;
    case (op)
      OP_AND:          fs = FS_AND;
      OP_ORR:          fs = FS_ORR;
      OP_SUB, OP_SUBS: fs = FS_SUB;
      default:         fs = FS_ADD;
    endcase
    return fs;
  endfunction

  always_comb begin
    case (cond)
      COND_EQ: cond_taken = flag_z;
      COND_NE: cond_taken = !flag_z;
      COND_GE: cond_taken = (flag_n == flag_v);
      COND_LT: cond_taken = (flag_n != flag_v);
      default: cond_taken = 1'b0;
    endcase
  end

  always_comb begin
    ctrl       = '0;
    constant   = '0;
    next_state = state;
    case (state)
      ST_FETCH: begin
        ctrl.en_pc = 1'b1;
        ctrl.ps    = PS_INC;
        next_state = ST_EXEC;
      end

      ST_EXEC: begin
        next_state = ST_FETCH;
        if (op11 == OP_LDUR) begin
          // Address phase only; the register write happens in MEM
          ctrl.fs    = FS_ADD;
          ctrl.b_sel = 1'b1;
          ctrl.sa    = rn;
          constant   = sext_imm9(ir[20:12]);
          next_state = ST_MEM;
        end else if (op11 == OP_STUR) begin
          ctrl.fs    = FS_ADD;
          ctrl.b_sel = 1'b1;
          ctrl.sa    = rn;
          ctrl.sb    = rd;
          ctrl.wm    = 1'b1;
          constant   = sext_imm9(ir[20:12]);
        end else if (is_rtype(op11)) begin
          ctrl.en_alu = 1'b1;
          ctrl.wr     = 1'b1;
          ctrl.sl     = (op11 == OP_SUBS);
          ctrl.fs     = rtype_fs(op11);
          ctrl.sa     = rn;
          ctrl.sb     = rm;
          ctrl.da     = rd;
        end else if ((op10 == OP_ADDI) || (op10 == OP_SUBI)) begin
          ctrl.en_alu = 1'b1;
          ctrl.wr     = 1'b1;
          ctrl.b_sel  = 1'b1;
          ctrl.fs     = (op10 == OP_SUBI) ? FS_SUB : FS_ADD;
          ctrl.sa     = rn;
          ctrl.da     = rd;
          constant    = zext_imm12(ir[21:10]);
        end else if (op8 == OP_CBZ) begin
          // XZR | Rt drives the ALU zero flag that selects the branch
          ctrl.sa = 5'd31;
          ctrl.sb = rd;
          ctrl.fs = FS_ORR;
          if (alu_zero) begin
            ctrl.ps  = PS_BRANCH;
            constant = sext_imm19_x4(ir[23:5]);
          end
        end else if (op8 == OP_BCOND) begin
          if (cond_taken) begin
            ctrl.ps  = PS_BRANCH;
            constant = sext_imm19_x4(ir[23:5]);
          end
        end else if (op6 == OP_B) begin
          ctrl.en_pc = 1'b1;
          ctrl.ps    = PS_BRANCH;
          constant   = sext_imm26_x4(ir[25:0]);
        end else begin
          next_state = ST_HALT;
        end
      end

      ST_MEM: begin
        // Keep the LDUR address stable while memory data is written back
        ctrl.fs     = FS_ADD;
        ctrl.b_sel  = 1'b1;
        ctrl.sa     = rn;
        ctrl.en_mem = 1'b1;
        ctrl.wr     = 1'b1;
        ctrl.da     = rd;
        constant    = sext_imm9(ir[20:12]);
        next_state  = ST_FETCH;
      end

      ST_HALT: begin
        next_state = ST_HALT;
      end

      default: begin
        next_state = ST_FETCH;
      end
    endcase
  end

endmodule

// File: rtl/legv8_multicycle_control.sv
// LEGv8 multicycle control unit (FETCH / EXEC / MEM / HALT).
// Holds only the FSM state and the instruction register; decoding is done
// by legv8_decoder. Outputs are combinational from state and IR.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset; outputs read 0 while low
//   bus   : slave side of legv8_multicycle_control_if
//           (run, instruction, status in; control_word, constant, IL, halted out)
module legv8_multicycle_control
  import legv8_multicycle_control_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  legv8_multicycle_control_if.slave bus
);

  state_t      state;
  state_t      next_state;
  logic [31:0] ir;
  ctrl_t       dec_ctrl;
  logic [63:0] dec_const;
  ctrl_t       cw;
  logic        il;

  legv8_decoder u_decoder (
    .state      (state),
    .ir         (ir),
    .status     (bus.status),
    .ctrl       (dec_ctrl),
    .constant   (dec_const),
    .next_state (next_state)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else if (bus.run) begin
      if (state == ST_FETCH) begin
        ir <= bus.instruction;
      end
      state <= next_state;
    end
  end

  always_comb begin
    cw = dec_ctrl;
    il = (state == ST_FETCH);
    // Freezing suppresses every side effect; address/select fields stay live
    if (!bus.run) begin
      cw.wr    = 1'b0;
      cw.wm    = 1'b0;
      cw.sl    = 1'b0;
      cw.en_pc = 1'b0;
      il       = 1'b0;
    end
    // Reset blanks outputs immediately, so an aborted EXEC/MEM never writes
    if (!reset) begin
      cw = '0;
      il = 1'b0;
    end
  end

  assign bus.control_word = cw;
  assign bus.constant     = reset ? dec_const : 64'd0;
  assign bus.IL           = il;
  assign bus.halted       = reset && (state == ST_HALT);

endmodule

// File: tb/tb_legv8_multicycle_control.sv
module tb_legv8_multicycle_control;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  legv8_multicycle_control_if bus ();

  legv8_multicycle_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [29:0] cw;
    logic [63:0] k;
    logic        il;
    logic        hl;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  localparam logic [31:0] I_ADD  = 32'h8B02_0023; // ADD  X3,X1,X2
  localparam logic [31:0] I_SUBS = 32'hEB03_0041; // SUBS X1,X2,X3
  localparam logic [31:0] I_ADDI = 32'h913F_FD09; // ADDI X9,X8,#0xFFF
  localparam logic [31:0] I_LDUR = 32'hF85F_8045; // LDUR X5,[X2,#-8]
  localparam logic [31:0] I_STUR = 32'hF801_0027; // STUR X7,[X1,#16]
  localparam logic [31:0] I_CBZ  = 32'hB400_0064; // CBZ  X4,#3
  localparam logic [31:0] I_BLT  = 32'h5400_00AB; // B.LT #5
  localparam logic [31:0] I_BEQ  = 32'h5400_0040; // B.EQ #2
  localparam logic [31:0] I_BGT  = 32'h5400_004C; // B.GT #2 (unsupported cond)
  localparam logic [31:0] I_B    = 32'h17FF_FFFF; // B    #-1
  localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;
  localparam logic [31:0] I_JUNK = 32'hDEAD_BEEF;

  function automatic logic [29:0] mk_cw(
    input logic en_pc, input logic en_mem, input logic en_alu, input logic bsel,
    input logic sl, input logic wm, input logic wr, input logic [1:0] ps,
    input logic [4:0] fs, input logic [4:0] sb, input logic [4:0] sa, input logic [4:0] da);
    return {en_pc, en_mem, en_alu, 1'b0, bsel, sl, wm, wr, ps, fs, sb, sa, da};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must show in it
  task automatic step(input string tag, input logic rst_v, input logic run_v,
                      input logic [31:0] ins, input logic [4:0] st,
                      input logic [29:0] e_cw, input logic [63:0] e_k,
                      input logic e_il, input logic e_hl);
    reset           = rst_v;
    bus.run         = run_v;
    bus.instruction = ins;
    bus.status      = st;
    exp_q.push_back({e_cw, e_k, e_il, e_hl});
    tag_q.push_back(tag);
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare mid-cycle, away from the rising edge
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq({t, ".cw"},     {34'd0, bus.control_word}, {34'd0, e.cw});
        check_eq({t, ".const"},  bus.constant, e.k);
        check_eq({t, ".il"},     {63'd0, bus.IL}, {63'd0, e.il});
        check_eq({t, ".halted"}, {63'd0, bus.halted}, {63'd0, e.hl});
        check_eq({t, ".mem_alu_excl"},
                 {63'd0, bus.control_word[28] & bus.control_word[27]}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] cw_fetch;
    logic [29:0] cw_zero;
    logic [29:0] cw_stur;
    logic [29:0] cw_ld_ex;
    cw_fetch = mk_cw(1,0,0,0,0,0,0,2'b01,5'd0,5'd0,5'd0,5'd0);
    cw_zero  = '0;
    cw_stur  = mk_cw(0,0,0,1,0,1,0,2'b00,5'b01000,5'd7,5'd1,5'd0);
    cw_ld_ex = mk_cw(0,0,0,1,0,0,0,2'b00,5'b01000,5'd0,5'd2,5'd0);

    reset           = 1'b0;
    bus.run         = 1'b1;
    bus.instruction = '0;
    bus.status      = '0;
    @(posedge clock);
    #1;

    // Reset held, then released into FETCH
    step("rst0", 0, 1, I_ADD, 5'd0, cw_zero, 64'd0, 0, 0);
    step("rst1", 0, 1, I_ADD, 5'd0, cw_zero, 64'd0, 0, 0);
    step("add.fetch", 1, 1, I_ADD, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("add.exec", 1, 1, I_JUNK, 5'd0,
         mk_cw(0,0,1,0,0,0,1,2'b00,5'b01000,5'd2,5'd1,5'd3), 64'd0, 0, 0);

    // SUBS sets flags; ADDI with the largest imm12
    step("subs.fetch", 1, 1, I_SUBS, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("subs.exec", 1, 1, I_JUNK, 5'd0,
         mk_cw(0,0,1,0,1,0,1,2'b00,5'b01001,5'd3,5'd2,5'd1), 64'd0, 0, 0);
    step("addi.fetch", 1, 1, I_ADDI, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("addi.exec", 1, 1, I_JUNK, 5'd0,
         mk_cw(0,0,1,1,0,0,1,2'b00,5'b01000,5'd0,5'd8,5'd9), 64'h0000_0000_0000_0FFF, 0, 0);

    // LDUR: FETCH, EXEC, MEM, then back to FETCH
    step("ldur.fetch", 1, 1, I_LDUR, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("ldur.exec", 1, 1, I_JUNK, 5'd0, cw_ld_ex, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
    step("ldur.mem", 1, 1, I_JUNK, 5'd0,
         mk_cw(0,1,0,1,0,0,1,2'b00,5'b01000,5'd0,5'd2,5'd5), 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);

    // Freeze in FETCH, then STUR frozen in EXEC for 3 cycles
    step("frz.fetch", 1, 0, I_JUNK, 5'd0,
         mk_cw(0,0,0,0,0,0,0,2'b01,5'd0,5'd0,5'd0,5'd0), 64'd0, 0, 0);
    step("stur.fetch", 1, 1, I_STUR, 5'd0, cw_fetch, 64'd0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step("stur.frozen", 1, 0, I_JUNK, 5'd0,
           mk_cw(0,0,0,1,0,0,0,2'b00,5'b01000,5'd7,5'd1,5'd0), 64'd16, 0, 0);
    end
    step("stur.exec", 1, 1, I_JUNK, 5'd0, cw_stur, 64'd16, 0, 0);

    // CBZ taken / not taken on the live zero flag
    step("cbz.fetch", 1, 1, I_CBZ, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("cbz.taken", 1, 1, I_JUNK, 5'b00001,
         mk_cw(0,0,0,0,0,0,0,2'b10,5'b00100,5'd4,5'd31,5'd0), 64'd12, 0, 0);
    step("cbz2.fetch", 1, 1, I_CBZ, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("cbz.not", 1, 1, I_JUNK, 5'b00000,
         mk_cw(0,0,0,0,0,0,0,2'b00,5'b00100,5'd4,5'd31,5'd0), 64'd0, 0, 0);

    // B.cond: LT both ways, EQ taken, unsupported cond never taken
    step("blt.fetch", 1, 1, I_BLT, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("blt.not", 1, 1, I_JUNK, 5'b10100, cw_zero, 64'd0, 0, 0);
    step("blt2.fetch", 1, 1, I_BLT, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("blt.taken", 1, 1, I_JUNK, 5'b00100,
         mk_cw(0,0,0,0,0,0,0,2'b10,5'd0,5'd0,5'd0,5'd0), 64'd20, 0, 0);
    step("beq.fetch", 1, 1, I_BEQ, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("beq.taken", 1, 1, I_JUNK, 5'b00010,
         mk_cw(0,0,0,0,0,0,0,2'b10,5'd0,5'd0,5'd0,5'd0), 64'd8, 0, 0);
    step("bgt.fetch", 1, 1, I_BGT, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("bgt.not", 1, 1, I_JUNK, 5'b00000, cw_zero, 64'd0, 0, 0);

    // Unconditional B with a negative offset
    step("b.fetch", 1, 1, I_B, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("b.exec", 1, 1, I_JUNK, 5'd0,
         mk_cw(1,0,0,0,0,0,0,2'b10,5'd0,5'd0,5'd0,5'd0), 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);

    // Reset aborts STUR in EXEC and LDUR in MEM with no write strobes
    step("abort1.fetch", 1, 1, I_STUR, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("abort1.rst", 0, 1, I_JUNK, 5'd0, cw_zero, 64'd0, 0, 0);
    step("abort1.refetch", 1, 1, I_LDUR, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("abort2.exec", 1, 1, I_JUNK, 5'd0, cw_ld_ex, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0);
    step("abort2.rst", 0, 1, I_JUNK, 5'd0, cw_zero, 64'd0, 0, 0);
    step("abort2.refetch", 1, 1, I_BAD, 5'd0, cw_fetch, 64'd0, 1, 0);

    // Illegal opcode: EXEC then HALT for 10 cycles, cleared only by reset
    step("bad.exec", 1, 1, I_ADD, 5'd0, cw_zero, 64'd0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step("halt", 1, 1, I_ADD, 5'b11111, cw_zero, 64'd0, 0, 1);
    end
    step("halt.rst", 0, 1, I_ADD, 5'd0, cw_zero, 64'd0, 0, 0);
    step("halt.refetch", 1, 1, I_ADD, 5'd0, cw_fetch, 64'd0, 1, 0);
    step("halt.add", 1, 1, I_JUNK, 5'd0,
         mk_cw(0,0,1,0,0,0,1,2'b00,5'b01000,5'd2,5'd1,5'd3), 64'd0, 0, 0);

    check_eq("drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
